// File: rtl/qd1_pio_pkg.sv
// Shared definitions for the button PIO: register addresses, edge selection
// and the per-bit edge filter.
package qd1_pio_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // prev/cur are the delayed and current debounced levels of one bit.
  function automatic logic edge_hit(edge_type_e edge_type, logic prev, logic cur);
    case (edge_type)
      EDGE_RISE: return ~prev & cur;
      EDGE_FALL: return prev & ~cur;
      default:   return prev ^ cur;
    endcase
  endfunction

endpackage

// File: rtl/qd1_debounce.sv
// Single-bit 2-flop synchronizer followed by a stability counter; the
// debounced level only follows the input after DEBOUNCE_CYCLES steady cycles.
module qd1_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic deb_o
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_inc == CNT_MAX) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      deb_q   <= IDLE_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/qd1_button_pio.sv
// Avalon-MM button PIO: debounced inputs, maskable edge capture with
// write-one-to-clear, and a level interrupt.
module qd1_button_pio
  import qd1_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter edge_type_e  EDGE_TYPE       = EDGE_FALL,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    qd1_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .in_i    (in_port[i]),
      .deb_o   (deb[i])
    );
    assign edge_det[i] = edge_hit(EDGE_TYPE, deb_dly_q[i], deb[i]);
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_writedata;
    assign unused_writedata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    mask_d   = mask_q;
    edge_clr = '0;
    if (wr_en && address == ADDR_MASK) mask_d   = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE) edge_clr = writedata[WIDTH-1:0];
    // A new edge is OR-ed in after the clear so it survives a same-cycle clear.
    edge_d = (edge_q & ~edge_clr) | edge_det;
  end

  // The delayed copy resets to the idle level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q <= {WIDTH{IDLE_LEVEL}};
      mask_q    <= '0;
      edge_q    <= '0;
    end else begin
      deb_dly_q <= deb;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = deb;
      ADDR_DIR:  readdata            = '0;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_q;
      default:   readdata            = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_qd1_button_pio.sv
// Bench for qd1_button_pio (WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture):
// directed scenarios plus a window-based reference model compared every cycle.
module tb_qd1_button_pio;
  import qd1_pio_pkg::*;

  localparam int D = 4;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [3:0]  in_port    = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qd1_button_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (D),
    .EDGE_TYPE       (EDGE_FALL),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronized stream is in_port two edges late; a bit's
  // accepted level flips once the last D synchronized samples all disagree with it.
  logic [3:0] m_deb, m_prev, m_edge, m_mask;
  logic [3:0] m_inq[$];
  logic [3:0] m_syncq[$];

  task automatic m_reset();
    m_deb   = 4'hF;
    m_prev  = 4'hF;
    m_edge  = 4'h0;
    m_mask  = 4'h0;
    m_inq   = {4'hF, 4'hF};
    m_syncq = {};
  endtask

  task automatic m_step();
    logic [3:0] clr, next_edge, s, nd;
    bit         all_diff;
    clr       = (chipselect && !write_n && address == ADDR_EDGE) ? writedata[3:0] : 4'h0;
    next_edge = (m_edge & ~clr) | (m_prev & ~m_deb);
    if (chipselect && !write_n && address == ADDR_MASK) m_mask = writedata[3:0];
    m_prev = m_deb;
    s = m_inq[1];
    m_inq.push_front(in_port);
    void'(m_inq.pop_back());
    m_syncq.push_front(s);
    if (m_syncq.size() > D) void'(m_syncq.pop_back());
    nd = m_deb;
    if (m_syncq.size() == D) begin
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) if (m_syncq[i][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) nd[b] = ~m_deb[b];
      end
    end
    m_deb  = nd;
    m_edge = next_edge;
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_deb};
      2'd2:    return {28'h0, m_mask};
      2'd3:    return {28'h0, m_edge};
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_readdata", readdata, exp_rd(address));
      check("model_irq", {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    logic [31:0] d;

    // Reset state with all buttons idle high.
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    at_neg();
    rd(2'd0, d); check("reset_data", d, 32'h0000000F);
    rd(2'd1, d); check("reset_dir", d, 32'h0);
    rd(2'd2, d); check("reset_mask", d, 32'h0);
    rd(2'd3, d); check("reset_edge", d, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);

    // Clean step on bit 0: data follows after 2+D edges, edge one edge later.
    @(posedge clk);
    #1 in_port = 4'hE;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      at_neg();
      rd(2'd0, d); check($sformatf("step_data_c%0d", k), d, (k < 6) ? 32'hF : 32'hE);
      rd(2'd3, d); check($sformatf("step_edge_c%0d", k), d, (k < 7) ? 32'h0 : 32'h1);
    end

    // Mask then clear: irq follows the register contents one cycle later.
    wr(2'd2, 32'h1);
    at_neg();
    check("mask_irq_on", {31'h0, irq}, 32'h1);
    rd(2'd2, d); check("mask_readback", d, 32'h1);
    wr(2'd3, 32'h1);
    at_neg();
    check("clear_irq_off", {31'h0, irq}, 32'h0);
    rd(2'd3, d); check("clear_edge", d, 32'h0);

    // Writes to data and direction are ignored.
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    at_neg();
    rd(2'd0, d); check("ro_data", d, 32'hE);
    rd(2'd1, d); check("ro_dir", d, 32'h0);

    // Three-cycle low glitch on bit 1 is rejected.
    @(posedge clk);
    #1 in_port = 4'hC;
    repeat (3) @(posedge clk);
    #1 in_port = 4'hE;
    repeat (10) @(posedge clk);
    at_neg();
    rd(2'd0, d); check("glitch_data", d, 32'hE);
    rd(2'd3, d); check("glitch_edge", d, 32'h0);

    // Bit 0 rises (not captured), then falls with a clear landing on the capture edge.
    @(posedge clk);
    #1 in_port = 4'hF;
    repeat (10) @(posedge clk);
    at_neg();
    rd(2'd3, d); check("rise_ignored", d, 32'h0);
    @(posedge clk);
    #1 in_port = 4'hE;
    repeat (5) @(posedge clk);
    wr(2'd3, 32'h1);
    at_neg();
    rd(2'd3, d); check("set_wins", d, 32'h1);
    check("set_wins_irq", {31'h0, irq}, 32'h1);

    // Reset mid-debounce, released with inputs idle: nothing captured.
    @(posedge clk);
    #1 in_port = 4'h0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #3 in_port = 4'hF;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    at_neg();
    rd(2'd0, d); check("rst_mid_data", d, 32'hF);
    rd(2'd3, d); check("rst_mid_edge", d, 32'h0);
    rd(2'd2, d); check("rst_mid_mask", d, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qd1_button_pio.md
QD1_BUTTON_PIO -- requirements
Module: qd1_button_pio

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 4, number of input bits.
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (>=1).
- EDGE_TYPE, EDGE_FALL, edge that sets edgecapture (EDGE_RISE / EDGE_FALL / EDGE_ANY).
- IDLE_LEVEL, 1'b1, reset value of synchronizer and debounced state, all bits.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset_n, in, 1, reset, asynchronous, active-low.
- address, in, 2, Avalon-MM word address.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write strobe.
- writedata, in, 32, write data.
- in_port, in, WIDTH, asynchronous button inputs.
- readdata, out, 32, read data, combinational.
- irq, out, 1, level interrupt request, active-high.

Function
REQ-003 Register map SHALL be: 0 data (RO), 1 direction (RO, reads 0), 2 interruptmask (RW), 3 edgecapture (RW1C).
REQ-004 readdata SHALL be valid in the same cycle as address, with no wait states; bits 31:WIDTH SHALL read 0; reads SHALL have no side effects.
REQ-005 Writes SHALL occur when chipselect=1 and write_n=0; writes to addresses 0 and 1 SHALL be ignored.
REQ-006 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-007 Per bit, a debounce counter SHALL count while the synchronized value differs from the debounced value.
- It SHALL reset to 0 whenever the two values are equal.
- It SHALL update the debounced value on the cycle the count reaches DEBOUNCE_CYCLES, then clear.
REQ-008 Latency from an in_port change to the data register SHALL be 2 + DEBOUNCE_CYCLES clk cycles for a clean step.
REQ-009 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced value and SHALL NOT set edgecapture.
REQ-010 An edge SHALL be detected by comparing the debounced value with its one-cycle-delayed copy, filtered by EDGE_TYPE.
REQ-011 A detected edge SHALL set the corresponding edgecapture bit on the next clk edge.
REQ-012 A write to address 3 SHALL clear each edgecapture bit whose writedata bit is 1.
REQ-013 If an edge and a clear for the same bit occur in the same cycle, the set SHALL win.
REQ-014 interruptmask SHALL load writedata[WIDTH-1:0] on a write to address 2.
REQ-015 irq SHALL equal OR(edgecapture AND interruptmask), derived combinationally from registers.
- irq SHALL change 1 cycle after the register update.
- irq SHALL be glitch-free with respect to address and read signals.
REQ-016 Changing the mask SHALL NOT alter edgecapture contents.
- Unmasking an already captured bit SHALL assert irq in the next cycle.

Reset
REQ-017 reset_n low SHALL asynchronously force the following values:
- synchronizer flops, debounced value and delayed copy: IDLE_LEVEL.
- debounce counters: 0.
- interruptmask: 0.
- edgecapture: 0.
- irq: 0.
REQ-018 Reset asserted mid-debounce SHALL discard the partial count.
- No edge SHALL be captured on release of reset, regardless of the in_port level.

Structure
REQ-019 Shared package qd1_pio_pkg SHALL hold:
- address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3.
- the EDGE_RISE/EDGE_FALL/EDGE_ANY enumeration.
REQ-020 Sub-module qd1_debounce SHALL implement the single-bit synchronizer, counter and debounced state.
- qd1_debounce SHALL be instantiated WIDTH times.
- Its counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_FALL)
REQ-021 After reset with in_port=4'hF: read addr 0 -> 32'h0000000F; reads of addr 2 and addr 3 -> 0; irq=0.
REQ-022 Step in_port to 4'hE and hold: addr 0 reads 4'hF for 5 cycles, reads 4'hE from cycle 6, and edgecapture=4'h1 the cycle after.
REQ-023 Drive bit 1 low for 3 cycles then high: data stays 4'hF, edgecapture stays 0.
REQ-024 Mask: write mask=4'h1 with edgecapture=4'h1 -> irq=1 next cycle; write addr 3 = 4'h1 -> edgecapture=0, irq=0 next cycle.
REQ-025 Same-cycle set and clear of bit 0 -> edgecapture bit 0 remains 1.
REQ-026 Assert reset_n with count at 3 and in_port=4'h0, then release with in_port=4'hF -> no edge captured, data=4'hF, irq=0.
